// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer in front of a combinational-read
// instruction memory. It owns the fetch PC, buffers fetched {pc, instr}
// pairs in a small prefetch FIFO, and hands them to decode over a
// valid/ready handshake. PC redirects flush the FIFO and restart fetching.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   slot_pc    [DEPTH];
  logic [31:0]   slot_instr [DEPTH];
  logic          push, pop, full;

  assign full      = (count_reg == CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready;
  // A simultaneous pop frees a slot, so a full FIFO can still accept a push.
  assign push      = (state_reg == FETCH) & ~halt & ~redirect_valid & (~full | pop);
  assign imem_addr = fetch_pc_reg;

  // Head is forced to zero when empty so decode never sees stale entries.
  assign out_instr = out_valid ? slot_instr[rd_ptr_reg] : '0;
  assign out_pc    = out_valid ? slot_pc[rd_ptr_reg]    : '0;

  // FIFO slots: each entry captures {fetch_pc, imem_instr} when it is the write target.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [31:0] entry_pc_reg;
      logic [31:0] entry_instr_reg;

      // Per-slot capture register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_pc_reg    <= '0;
          entry_instr_reg <= '0;
        end else if (push && (wr_ptr_reg == AW'(gi))) begin
          entry_pc_reg    <= fetch_pc_reg;
          entry_instr_reg <= imem_instr;
        end
      end

      assign slot_pc[gi]    = entry_pc_reg;
      assign slot_instr[gi] = entry_instr_reg;
    end
  endgenerate

  // FSM next state: halt wins over fetching, a redirect does not change that.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:   if (halt)  state_next = HALTED;
      HALTED:  if (!halt) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Pointer, occupancy and fetch PC updates; redirect flushes and overrides everything.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (push) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
        wr_ptr_next   = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven cycle checks of fetch_unit plus a scoreboard
// of expected fetch PCs that is consumed on every real handshake.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];

  typedef struct {
    logic        ready;
    logic        hlt;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[26];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Instruction memory model: a distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic h, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ea);
    vec_t v;
    v.ready = r; v.hlt = h; v.rv = rv; v.rpc = rpc;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic sb_fill(input logic [31:0] start);
    logic [31:0] p;
    sb_q.delete();
    p = start;
    for (int i = 0; i < 12; i++) begin
      sb_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // Called when a real (non-squashed) handshake is about to happen.
  task automatic sb_pop();
    logic [31:0] e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got handshake pc=%h required no handshake", out_pc);
    end else begin
      checks--;
      e = sb_q.pop_front();
      check("sb_pc", out_pc, e);
      check("sb_instr", out_instr, mem_word(e));
    end
  endtask

  initial begin
    vec_t v;
    logic [31:0] ei;

    //            ready halt rv  rpc           valid pc            addr
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,        32'h4);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,        32'h8);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,        32'h8);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,        32'h8);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,        32'h8);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h4,        32'hC);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h8,        32'h10);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 32'h0000_0015,  1'b1, 32'h8,        32'h10);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,        32'h14);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h14,       32'h18);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h18,       32'h1C);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,        32'h1C);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,        32'h1C);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,        32'h1C);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,        32'h1C);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,        32'h1C);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h1C,       32'h20);
    vecs[17] = mk(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC,  1'b1, 32'h20,       32'h24);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,        32'hFFFF_FFFC);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'hFFFF_FFFC, 32'h0);
    vecs[20] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,        32'h4);
    vecs[21] = mk(1'b1, 1'b1, 1'b1, 32'h0000_0040,  1'b1, 32'h4,        32'h8);
    vecs[22] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,        32'h40);
    vecs[23] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,        32'h40);
    vecs[24] = mk(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h40,       32'h44);
    vecs[25] = mk(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h40,       32'h48);

    reset = 1'b1;
    out_ready = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Outputs are all zero while reset is held, across a clock edge.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_instr", out_instr, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
    end

    // Release reset and run the cycle-accurate vector table.
    reset = 1'b0;
    sb_fill(32'h0);
    for (int r = 0; r < 26; r++) begin
      v = vecs[r];
      @(negedge clk);
      ei = v.exp_valid ? mem_word(v.exp_pc) : 32'h0;
      check($sformatf("row%0d_valid", r), {31'b0, out_valid}, {31'b0, v.exp_valid});
      check($sformatf("row%0d_pc", r), out_pc, v.exp_pc);
      check($sformatf("row%0d_instr", r), out_instr, ei);
      check($sformatf("row%0d_addr", r), imem_addr, v.exp_addr);
      if (out_valid && v.ready && !v.rv) sb_pop();
      out_ready      = v.ready;
      halt           = v.hlt;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      if (v.rv) sb_fill({v.rpc[31:2], 2'b00});
      $display("row %0d: ready=%0b halt=%0b redirect=%0b valid=%0b pc=%h instr=%h addr=%h",
               r, v.ready, v.hlt, v.rv, out_valid, out_pc, out_instr, imem_addr);
    end

    // FIFO is full here with out_ready low; assert reset between edges.
    @(negedge clk);
    check("full_valid", {31'b0, out_valid}, 32'h1);
    check("full_pc", out_pc, 32'h40);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", {31'b0, out_valid}, 32'h0);
    check("async_pc", out_pc, 32'h0);
    check("async_instr", out_instr, 32'h0);
    check("async_addr", imem_addr, 32'h0);
    $display("async reset: valid=%0b pc=%h instr=%h addr=%h", out_valid, out_pc, out_instr, imem_addr);

    // Restart with out_ready high: one instruction per cycle from PC 0.
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_fill(32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("stream%0d_valid", k), {31'b0, out_valid}, 32'h1);
      check($sformatf("stream%0d_pc", k), out_pc, 32'(k * 4));
      check($sformatf("stream%0d_addr", k), imem_addr, 32'(k * 4 + 4));
      if (out_valid) sb_pop();
      $display("stream %0d: valid=%0b pc=%h instr=%h", k, out_valid, out_pc, out_instr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
